// File: rtl/alarm_timer_sequencer.sv
// Avalon-MM master for the interval timer: programs period/IRQ enable, services
// timeouts, keeps a 24h hh:mm:ss time of day and raises an alarm ring flag.
module alarm_timer_sequencer #(
  parameter logic [31:0] PERIOD  = 32'h02FAF07F,
  parameter int unsigned CLR_GAP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  input  logic        set_time,
  input  logic [4:0]  set_hour,
  input  logic [5:0]  set_min,
  input  logic        alarm_en,
  input  logic [4:0]  alarm_hour,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_ack,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic        tick,
  output logic        alarm_ring,
  output logic        busy
);

  localparam logic [2:0] W_PL   = 3'd0;
  localparam logic [2:0] W_PH   = 3'd1;
  localparam logic [2:0] W_CTRL = 3'd2;
  localparam logic [2:0] IDLE   = 3'd3;
  localparam logic [2:0] CLR    = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  localparam logic [7:0] GAP_LAST = 8'(CLR_GAP - 32'd1);

  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    if (h > 5'd23) begin
      clamp_hour = 5'd23;
    end else begin
      clamp_hour = h;
    end
  endfunction

  function automatic logic [5:0] clamp_min(input logic [5:0] m);
    if (m > 6'd59) begin
      clamp_min = 6'd59;
    end else begin
      clamp_min = m;
    end
  endfunction

  logic [2:0]  state_r, state_nxt_s;
  logic        take_set_s;
  logic        cs_r, write_n_r;
  logic [2:0]  addr_r;
  logic [15:0] wdata_r;
  logic        cs_nxt_s;
  logic [2:0]  addr_nxt_s;
  logic [15:0] wdata_nxt_s;
  logic [4:0]  hour_r, adv_hour_s, set_h_s, pend_hour_r;
  logic [5:0]  min_r, adv_min_s, set_m_s, pend_min_r;
  logic [5:0]  sec_r, adv_sec_s;
  logic        tick_r, ring_r, busy_r;
  logic        reload_only_r, set_pend_r;
  logic [7:0]  gap_cnt_r;
  logic        alarm_match_s;

  // Next-state selection; W_PL after reset first spends a cycle issuing its write.
  always_comb begin
    state_nxt_s = state_r;
    take_set_s  = 1'b0;
    case (state_r)
      W_PL: begin
        if (cs_r) begin
          state_nxt_s = W_PH;
        end else begin
          state_nxt_s = W_PL;
        end
      end
      W_PH: begin
        if (reload_only_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = W_CTRL;
        end
      end
      W_CTRL: state_nxt_s = IDLE;
      IDLE: begin
        if (set_time || set_pend_r) begin
          state_nxt_s = W_PL;
          take_set_s  = 1'b1;
        end else if (tmr_irq) begin
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLR: begin
        if (CLR_GAP == 32'd0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_r >= GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: state_nxt_s = W_PL;
    endcase
  end

  // Bus strobe for the state being entered, so each write lines up with its state cycle.
  always_comb begin
    cs_nxt_s    = 1'b0;
    addr_nxt_s  = 3'd0;
    wdata_nxt_s = 16'd0;
    case (state_nxt_s)
      W_PL: begin
        cs_nxt_s    = 1'b1;
        addr_nxt_s  = 3'd2;
        wdata_nxt_s = PERIOD[15:0];
      end
      W_PH: begin
        cs_nxt_s    = 1'b1;
        addr_nxt_s  = 3'd3;
        wdata_nxt_s = PERIOD[31:16];
      end
      W_CTRL: begin
        cs_nxt_s    = 1'b1;
        addr_nxt_s  = 3'd1;
        wdata_nxt_s = 16'h0001;
      end
      CLR: begin
        cs_nxt_s    = 1'b1;
        addr_nxt_s  = 3'd0;
        wdata_nxt_s = 16'h0000;
      end
      default: begin
        cs_nxt_s    = 1'b0;
        addr_nxt_s  = 3'd0;
        wdata_nxt_s = 16'd0;
      end
    endcase
  end

  // One-second advance with minute/hour carries and 24h wrap.
  always_comb begin
    adv_sec_s  = sec_r;
    adv_min_s  = min_r;
    adv_hour_s = hour_r;
    if (sec_r >= 6'd59) begin
      adv_sec_s = 6'd0;
      if (min_r >= 6'd59) begin
        adv_min_s = 6'd0;
        if (hour_r >= 5'd23) begin
          adv_hour_s = 5'd0;
        end else begin
          adv_hour_s = hour_r + 5'd1;
        end
      end else begin
        adv_min_s = min_r + 6'd1;
      end
    end else begin
      adv_sec_s = sec_r + 6'd1;
    end
  end

  // Set values: a live pulse wins, otherwise the ones latched while busy.
  always_comb begin
    set_h_s = pend_hour_r;
    set_m_s = pend_min_r;
    if (set_time) begin
      set_h_s = clamp_hour(set_hour);
      set_m_s = clamp_min(set_min);
    end else begin
      set_h_s = pend_hour_r;
      set_m_s = pend_min_r;
    end
  end

  assign alarm_match_s = (adv_hour_s == alarm_hour) && (adv_min_s == alarm_min) &&
                         (adv_sec_s == 6'd0);

  // State, bus registers and GAP counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= W_PL;
      cs_r      <= 1'b0;
      write_n_r <= 1'b1;
      addr_r    <= 3'd0;
      wdata_r   <= 16'd0;
      busy_r    <= 1'b0;
      gap_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      cs_r      <= cs_nxt_s;
      write_n_r <= ~cs_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + 8'd1;
      end else begin
        gap_cnt_r <= 8'd0;
      end
    end
  end

  // Time of day, tick pulse and set-request bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour_r        <= 5'd0;
      min_r         <= 6'd0;
      sec_r         <= 6'd0;
      tick_r        <= 1'b0;
      reload_only_r <= 1'b0;
      set_pend_r    <= 1'b0;
      pend_hour_r   <= 5'd0;
      pend_min_r    <= 6'd0;
    end else begin
      tick_r <= (state_r == CLR);
      if (take_set_s) begin
        hour_r        <= set_h_s;
        min_r         <= set_m_s;
        sec_r         <= 6'd0;
        reload_only_r <= 1'b1;
      end else if (state_r == CLR) begin
        hour_r <= adv_hour_s;
        min_r  <= adv_min_s;
        sec_r  <= adv_sec_s;
      end else begin
        hour_r <= hour_r;
        min_r  <= min_r;
        sec_r  <= sec_r;
      end
      if (take_set_s) begin
        set_pend_r <= 1'b0;
      end else if (set_time) begin
        set_pend_r  <= 1'b1;
        pend_hour_r <= clamp_hour(set_hour);
        pend_min_r  <= clamp_min(set_min);
      end else begin
        set_pend_r <= set_pend_r;
      end
    end
  end

  // Alarm ring: ack or disable beats a same-cycle match; only timeouts can ring.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ring_r <= 1'b0;
    end else if (!alarm_en || alarm_ack) begin
      ring_r <= 1'b0;
    end else if ((state_r == CLR) && alarm_match_s) begin
      ring_r <= 1'b1;
    end else begin
      ring_r <= ring_r;
    end
  end

  assign tmr_address    = addr_r;
  assign tmr_chipselect = cs_r;
  assign tmr_write_n    = write_n_r;
  assign tmr_writedata  = wdata_r;
  assign hour           = hour_r;
  assign minute         = min_r;
  assign second         = sec_r;
  assign tick           = tick_r;
  assign alarm_ring     = ring_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_alarm_timer_sequencer.sv
// Self-checking bench for alarm_timer_sequencer: directed sequences, a set/irq
// vector table and a randomized run against a seconds-of-day reference model.
module tb_alarm_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq = 1'b0;
  logic        set_time = 1'b0;
  logic [4:0]  set_hour = 5'd0;
  logic [5:0]  set_min = 6'd0;
  logic        alarm_en = 1'b0;
  logic [4:0]  alarm_hour = 5'd0;
  logic [5:0]  alarm_min = 6'd0;
  logic        alarm_ack = 1'b0;
  logic [4:0]  hour;
  logic [5:0]  minute, second;
  logic        tick, alarm_ring, busy;

  alarm_timer_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .set_time(set_time), .set_hour(set_hour), .set_min(set_min),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_ack(alarm_ack), .hour(hour), .minute(minute), .second(second),
    .tick(tick), .alarm_ring(alarm_ring), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct {
    logic [4:0] sh; logic [5:0] sm; int nirq;
    logic [4:0] eh; logic [5:0] em; logic [5:0] es;
  } vec_t;

  wr_t wq[$];
  int  cyc_cnt = 0;
  int  tick_cnt = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Bus/tick monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) wq.push_back('{tmr_address, tmr_writedata, cyc_cnt});
    if (tick) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [40:0] outs();
    return {tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
            hour, minute, second, tick, alarm_ring, busy};
  endfunction

  task automatic chk_time(input string nm, input int h, input int m, input int s);
    chk({nm, "_hour"}, hour, h);
    chk({nm, "_min"}, minute, m);
    chk({nm, "_sec"}, second, s);
  endtask

  task automatic service_start();
    bit ok = 1'b0;
    int base = wq.size();
    tmr_irq = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (wq.size() > base) begin
        if (wq[wq.size()-1].addr == 3'd0) ok = 1'b1;
      end
    end
    chk("svc_status_write", ok, 1);
  endtask

  task automatic service();
    service_start();
    cyc();
    tmr_irq = 1'b0;
    cyc(2);
  endtask

  task automatic set_tm(input logic [4:0] h, input logic [5:0] m);
    set_hour = h;
    set_min  = m;
    set_time = 1'b1;
    cyc();
    set_time = 1'b0;
    cyc(4);
  endtask

  task automatic chk_init_writes(input string nm, input int base);
    chk({nm, "_count"}, wq.size() - base, 3);
    if (wq.size() >= base + 3) begin
      chk({nm, "_w0"}, {wq[base].addr, wq[base].data}, {3'd2, 16'hF07F});
      chk({nm, "_w1"}, {wq[base+1].addr, wq[base+1].data}, {3'd3, 16'h02FA});
      chk({nm, "_w2"}, {wq[base+2].addr, wq[base+2].data}, {3'd1, 16'h0001});
      chk({nm, "_consec"}, wq[base+2].cyc - wq[base].cyc, 2);
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic [40:0] zero_v;
    logic [2:0] exp_a [6];
    int base, c0, t0, n0;
    bit found;
    int tod, ring_m, en_m, ah, am, op, h, m, t;

    tbl[0] = '{5'd23, 6'd59, 60, 5'd0,  6'd0,  6'd0};
    tbl[1] = '{5'd5,  6'd10, 0,  5'd5,  6'd10, 6'd0};
    tbl[2] = '{5'd30, 6'd63, 1,  5'd23, 6'd59, 6'd1};
    tbl[3] = '{5'd12, 6'd59, 61, 5'd13, 6'd0,  6'd1};
    tbl[4] = '{5'd0,  6'd0,  3,  5'd0,  6'd0,  6'd3};
    zero_v = {3'd0, 1'b0, 1'b1, 16'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    exp_a  = '{3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0};

    // Reset values and the power-up programming sequence.
    #1 reset_n = 1'b0;
    cyc(2);
    chk("reset_outputs", outs(), zero_v);
    base = wq.size();
    reset_n = 1'b1;
    cyc(6);
    chk_init_writes("init", base);
    chk("init_busy", busy, 0);
    chk("init_bus_idle", {tmr_chipselect, tmr_write_n}, 2'b01);

    // Single timeout: latency, one status write, one tick, quiet GAP.
    base = wq.size();
    n0 = tick_cnt;
    c0 = cyc_cnt;
    tmr_irq = 1'b1;
    cyc();
    chk("irq_write_seen", wq.size() - base, 1);
    if (wq.size() > base) begin
      chk("irq_write_latency", wq[base].cyc - c0, 1);
      chk("irq_write", {wq[base].addr, wq[base].data}, {3'd0, 16'h0000});
    end
    chk("irq_sec_before", second, 0);
    cyc();
    chk("irq_tick", tick, 1);
    chk("irq_sec", second, 1);
    tmr_irq = 1'b0;
    cyc();
    chk("irq_tick_low", tick, 0);
    chk("irq_sec_gap", second, 1);
    cyc(2);
    chk("irq_one_write", wq.size() - base, 1);
    chk("irq_one_tick", tick_cnt - n0, 1);
    chk("irq_busy", busy, 0);

    // Vector table: set time, apply timeouts, compare the resulting time.
    for (int i = 0; i < 5; i++) begin
      base = wq.size();
      set_tm(tbl[i].sh, tbl[i].sm);
      chk("set_wr_count", wq.size() - base, 2);
      if (wq.size() >= base + 2) begin
        chk("set_wr0", {wq[base].addr, wq[base].data}, {3'd2, 16'hF07F});
        chk("set_wr1", {wq[base+1].addr, wq[base+1].data}, {3'd3, 16'h02FA});
      end
      for (int k = 0; k < tbl[i].nirq; k++) service();
      chk_time("vec", tbl[i].eh, tbl[i].em, tbl[i].es);
    end

    // Alarm at 07:30 reached from 07:29.
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    alarm_en   = 1'b1;
    set_tm(5'd7, 6'd29);
    chk("alarm_no_ring_on_set", alarm_ring, 0);
    for (int k = 0; k < 59; k++) service();
    chk("alarm_pre", alarm_ring, 0);
    chk_time("alarm_pre", 7, 29, 59);
    service_start();
    cyc();
    chk("alarm_tick", tick, 1);
    chk("alarm_ring", alarm_ring, 1);
    chk_time("alarm_hit", 7, 30, 0);
    tmr_irq = 1'b0;
    cyc(2);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    chk("alarm_ack", alarm_ring, 0);
    for (int k = 0; k < 3; k++) service();
    chk("alarm_no_rering", alarm_ring, 0);
    alarm_en = 1'b0;

    // set_time during W_CTRL while a timeout is pending.
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    base = wq.size();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (wq.size() > base) begin
        if (wq[wq.size()-1].addr == 3'd1) found = 1'b1;
      end
    end
    chk("wctrl_reached", found, 1);
    set_hour = 5'd10;
    set_min  = 6'd20;
    set_time = 1'b1;
    tmr_irq  = 1'b1;
    cyc();
    set_time = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (wq.size() > base) begin
        if (wq[wq.size()-1].addr == 3'd0) found = 1'b1;
      end
    end
    chk("pend_status_write", found, 1);
    cyc();
    tmr_irq = 1'b0;
    cyc(2);
    chk("pend_wr_count", wq.size() - base, 6);
    if (wq.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) chk("pend_wr_addr", wq[base+i].addr, exp_a[i]);
    end
    chk_time("pend", 10, 20, 1);

    // Asynchronous reset in GAP at 12:00:05.
    set_tm(5'd12, 6'd0);
    for (int k = 0; k < 4; k++) service();
    service_start();
    cyc();
    chk_time("gap_pre", 12, 0, 5);
    reset_n = 1'b0;
    #1;
    chk("gap_reset_outputs", outs(), zero_v);
    tmr_irq = 1'b0;
    cyc(2);
    base = wq.size();
    reset_n = 1'b1;
    cyc(6);
    chk_init_writes("reinit", base);
    chk_time("reinit", 0, 0, 0);

    // Randomized run against a seconds-of-day model.
    ring_m = 0;
    en_m = 0;
    ah = 0;
    am = 0;
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    set_tm(5'(h), 6'(m));
    tod = h * 3600 + m * 60;
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 19);
      if (op <= 13) begin
        service();
        tod = (tod + 1) % 86400;
        if (en_m != 0 && tod == ah * 3600 + am * 60) ring_m = 1;
      end else if (op == 14) begin
        h = $urandom_range(0, 31);
        m = $urandom_range(0, 63);
        set_tm(5'(h), 6'(m));
        tod = ((h > 23) ? 23 : h) * 3600 + ((m > 59) ? 59 : m) * 60;
      end else if (op == 15) begin
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        ring_m = 0;
      end else if (op <= 17) begin
        en_m = (en_m != 0) ? 0 : 1;
        alarm_en = (en_m != 0);
        cyc();
        if (en_m == 0) ring_m = 0;
      end else begin
        t = (tod / 60 + 1) % 1440;
        ah = t / 60;
        am = t % 60;
        alarm_hour = 5'(ah);
        alarm_min  = 6'(am);
        en_m = 1;
        alarm_en = 1'b1;
        cyc();
      end
      chk_time("rand", tod / 3600, (tod / 60) % 60, tod % 60);
      chk("rand_ring", alarm_ring, ring_m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
